// File: rtl/traffic_light_fsm.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_fsm
// Purpose  : Highway/farm-road phase sequencer that drives two restartable timers.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_fsm #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_sensor,
  input  logic       long_done,
  input  logic       short_done,
  output logic       st_long,
  output logic       st_short,
  output logic [2:0] hw_light,
  output logic [2:0] farm_light,
  output logic       car_pend,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    FG  = 3'd3,
    FY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  localparam logic [2:0] c_red = 3'b100;
  localparam logic [2:0] c_yel = 3'b010;
  localparam logic [2:0] c_grn = 3'b001;

  // Raw bits so that unencoded values can be held and recovered from.
  logic [2:0]             state_q;
  state_t                 state_d;
  logic                   st_long_q, st_long_d;
  logic                   st_short_q, st_short_d;
  logic [2:0]             hw_q, hw_d;
  logic [2:0]             farm_q, farm_d;
  logic                   car_pend_q, car_pend_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   long_ok, short_ok, car_sync;

  // A done seen while its restart pulse is still out belongs to the old phase.
  assign long_ok  = long_done  & ~st_long_q;
  assign short_ok = short_done & ~st_short_q;
  assign car_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = HG;
    st_long_d  = 1'b0;
    st_short_d = 1'b0;
    case (state_q)
      HG: begin
        if (long_ok && car_pend_q) begin
          state_d    = HY;
          st_short_d = 1'b1;
        end else begin
          state_d = HG;
        end
      end
      HY: begin
        if (short_ok) begin
          state_d    = AR1;
          st_short_d = 1'b1;
        end else begin
          state_d = HY;
        end
      end
      AR1: begin
        if (short_ok) begin
          state_d   = FG;
          st_long_d = 1'b1;
        end else begin
          state_d = AR1;
        end
      end
      FG: begin
        if (long_ok) begin
          state_d    = FY;
          st_short_d = 1'b1;
        end else begin
          state_d = FG;
        end
      end
      FY: begin
        if (short_ok) begin
          state_d    = AR2;
          st_short_d = 1'b1;
        end else begin
          state_d = FY;
        end
      end
      AR2: begin
        if (short_ok) begin
          state_d   = HG;
          st_long_d = 1'b1;
        end else begin
          state_d = AR2;
        end
      end
      default: begin
        state_d   = HG;
        st_long_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    hw_d   = c_red;
    farm_d = c_red;
    case (state_d)
      HG:      hw_d   = c_grn;
      HY:      hw_d   = c_yel;
      FG:      farm_d = c_grn;
      FY:      farm_d = c_yel;
      default: begin
        hw_d   = c_red;
        farm_d = c_red;
      end
    endcase
  end

  // Entering FG serves the request; clearing beats a coincident set.
  always_comb begin
    car_pend_d = car_pend_q | car_sync;
    if ((state_d == FG) && (state_q != FG)) begin
      car_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HG;
      st_long_q  <= 1'b1;
      st_short_q <= 1'b0;
      hw_q       <= c_grn;
      farm_q     <= c_red;
      car_pend_q <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      st_long_q  <= st_long_d;
      st_short_q <= st_short_d;
      hw_q       <= hw_d;
      farm_q     <= farm_d;
      car_pend_q <= car_pend_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], car_sensor};
    end
  end

  assign st_long    = st_long_q;
  assign st_short   = st_short_q;
  assign hw_light   = hw_q;
  assign farm_light = farm_q;
  assign car_pend   = car_pend_q;
  assign state_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_fsm
// Purpose  : Self-checking bench for traffic_light_fsm with behavioural timers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_fsm;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       car_sensor = 1'b0;
  logic       long_done  = 1'b1;
  logic       short_done = 1'b1;
  logic       st_long, st_short, car_pend;
  logic [2:0] hw_light, farm_light, state_o;
  logic [3:0] lcnt = 4'd7;
  logic [3:0] scnt = 4'd7;
  int         total = 0;
  int         bad   = 0;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] hw;
    logic [2:0] farm;
    logic       stl;
    logic       sts;
    logic       pend;
  } exp_t;

  typedef struct {
    logic [2:0] st;
    logic [2:0] hw;
    logic [2:0] farm;
    logic       stl;
    logic       sts;
    int         pend_from;
    bit         pulse;
  } phase_t;

  exp_t   sb[$];
  phase_t cur[$];

  always #5 clk = ~clk;

  traffic_light_fsm #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .car_sensor (car_sensor),
    .long_done  (long_done),
    .short_done (short_done),
    .st_long    (st_long),
    .st_short   (st_short),
    .hw_light   (hw_light),
    .farm_light (farm_light),
    .car_pend   (car_pend),
    .state_o    (state_o)
  );

  // Timers: done drops on the edge that samples st, rises 8 edges later; no reset.
  always @(posedge clk) begin
    if (st_long) begin
      lcnt      <= 4'd0;
      long_done <= 1'b0;
    end else if (lcnt < 4'd7) lcnt <= lcnt + 4'd1;
    else long_done <= 1'b1;
  end

  always @(posedge clk) begin
    if (st_short) begin
      scnt       <= 4'd0;
      short_done <= 1'b0;
    end else if (scnt < 4'd7) scnt <= scnt + 4'd1;
    else short_done <= 1'b1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t actual();
    return {state_o, hw_light, farm_light, st_long, st_short, car_pend};
  endfunction

  function automatic phase_t ph(input logic [2:0] st, input logic [2:0] hw,
                                input logic [2:0] farm, input logic stl,
                                input logic sts, input int pf, input bit pulse);
    phase_t p;
    p.st = st; p.hw = hw; p.farm = farm; p.stl = stl; p.sts = sts;
    p.pend_from = pf; p.pulse = pulse;
    return p;
  endfunction

  task automatic run_phases();
    foreach (cur[p]) begin
      for (int c = 0; c < 10; c++) begin
        exp_t e;
        exp_t w;
        e.st   = cur[p].st;
        e.hw   = cur[p].hw;
        e.farm = cur[p].farm;
        e.stl  = (c == 0) ? cur[p].stl : 1'b0;
        e.sts  = (c == 0) ? cur[p].sts : 1'b0;
        e.pend = (c >= cur[p].pend_from);
        sb.push_back(e);
        step();
        w = sb.pop_front();
        check($sformatf("phase%0d_c%0d", cur[p].st, c), actual(), w);
        check("lamp_excl", {15'd0, (hw_light != 3'b100) && (farm_light != 3'b100)}, 16'd0);
        if (cur[p].pulse && c == 2) car_sensor = 1'b1;
        if (cur[p].pulse && c == 3) car_sensor = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset state and the single st_long cycle after release
    repeat (3) @(posedge clk);
    #1;
    check("reset_vals", actual(), {3'd0, 3'b001, 3'b100, 1'b1, 1'b0, 1'b0});
    @(negedge clk) rst = 1'b0;
    #1;
    check("rel_st_long", {15'd0, st_long}, 16'd1);
    step();
    check("first_edge", actual(), {3'd0, 3'b001, 3'b100, 1'b0, 1'b0, 1'b0});

    // No car: highway green is held indefinitely
    for (int i = 0; i < 200; i++) begin
      step();
      check("idle_hg", actual(), {3'd0, 3'b001, 3'b100, 1'b0, 1'b0, 1'b0});
    end

    // Car arrives with long_done already high: latch after sync, leave HG next edge
    car_sensor = 1'b1;
    step();
    check("pend_sync1", {15'd0, car_pend}, 16'd0);
    step();
    check("pend_sync2", {15'd0, car_pend}, 16'd0);
    step();
    check("pend_set", actual(), {3'd0, 3'b001, 3'b100, 1'b0, 1'b0, 1'b1});

    cur.delete();
    cur.push_back(ph(3'd1, 3'b010, 3'b100, 1'b0, 1'b1, 0, 1'b0));
    cur.push_back(ph(3'd2, 3'b100, 3'b100, 1'b0, 1'b1, 0, 1'b0));
    cur.push_back(ph(3'd3, 3'b100, 3'b001, 1'b1, 1'b0, 1, 1'b0));
    cur.push_back(ph(3'd4, 3'b100, 3'b010, 1'b0, 1'b1, 0, 1'b0));
    cur.push_back(ph(3'd5, 3'b100, 3'b100, 1'b0, 1'b1, 0, 1'b0));
    cur.push_back(ph(3'd0, 3'b001, 3'b100, 1'b1, 1'b0, 0, 1'b0));
    cur.push_back(ph(3'd1, 3'b010, 3'b100, 1'b0, 1'b1, 0, 1'b0));
    run_phases();

    // Car leaves; a one-cycle pulse during FG must re-latch the request
    car_sensor = 1'b0;
    cur.delete();
    cur.push_back(ph(3'd2, 3'b100, 3'b100, 1'b0, 1'b1, 0, 1'b0));
    cur.push_back(ph(3'd3, 3'b100, 3'b001, 1'b1, 1'b0, 5, 1'b1));
    cur.push_back(ph(3'd4, 3'b100, 3'b010, 1'b0, 1'b1, 0, 1'b0));
    cur.push_back(ph(3'd5, 3'b100, 3'b100, 1'b0, 1'b1, 0, 1'b0));
    cur.push_back(ph(3'd0, 3'b001, 3'b100, 1'b1, 1'b0, 0, 1'b0));
    cur.push_back(ph(3'd1, 3'b010, 3'b100, 1'b0, 1'b1, 0, 1'b0));
    cur.push_back(ph(3'd2, 3'b100, 3'b100, 1'b0, 1'b1, 0, 1'b0));
    cur.push_back(ph(3'd3, 3'b100, 3'b001, 1'b1, 1'b0, 10, 1'b0));
    run_phases();

    // Reset asserted mid-FY takes effect without a clock edge
    step();
    check("fy_entry", actual(), {3'd4, 3'b100, 3'b010, 1'b0, 1'b1, 1'b0});
    step();
    step();
    check("fy_hold", actual(), {3'd4, 3'b100, 3'b010, 1'b0, 1'b0, 1'b0});
    #3 rst = 1'b1;
    #1;
    check("async_rst", actual(), {3'd0, 3'b001, 3'b100, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      step();
      check("in_rst", actual(), {3'd0, 3'b001, 3'b100, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk) rst = 1'b0;
    #1;
    check("rel2_st_long", {15'd0, st_long}, 16'd1);
    step();
    check("rel2_edge", actual(), {3'd0, 3'b001, 3'b100, 1'b0, 1'b0, 1'b0});
    car_sensor = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k < 9) check("resume_hg", {11'd0, state_o, st_long, st_short}, {11'd0, 3'd0, 1'b0, 1'b0});
      else       check("resume_hy", actual(), {3'd1, 3'b010, 3'b100, 1'b0, 1'b1, 1'b1});
    end

    // Unencoded state recovers to HG with a long-timer restart
    @(negedge clk);
    force dut.state_q = 3'd6;
    #1;
    check("forced", {13'd0, state_o}, 16'd6);
    release dut.state_q;
    step();
    check("recover", {6'd0, state_o, hw_light, farm_light, st_long},
                     {6'd0, 3'd0, 3'b001, 3'b100, 1'b1});
    step();
    check("recover_pulse", {15'd0, st_long}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Phase sequencer for a highway / farm-road intersection.
- Drives the restart inputs of the long and short phase timers and consumes their done outputs.
- Sequences the light outputs for both roads.
- Sits directly upstream of the timers: its st_long/st_short outputs feed their st inputs; their y outputs return as long_done/short_done.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the car_sensor synchroniser (legal range 2..4).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- car_sensor  in  1  raw farm-road vehicle detector, asynchronous level
- long_done  in  1  long-timer expired (level, held until next st_long)
- short_done  in  1  short-timer expired (level, held until next st_short)
- st_long  out  1  registered one-cycle restart pulse to long timer
- st_short  out  1  registered one-cycle restart pulse to short timer
- hw_light  out  3  highway lamps {red,yellow,green}, one-hot, registered
- farm_light  out  3  farm-road lamps {red,yellow,green}, one-hot, registered
- car_pend  out  1  latched farm-road request
- state_o  out  3  current state encoding, for debug

Behaviour:
- Reset is clk, rst as decided: asynchronous, active-high.
- Reset values:
  - state=HG (0); st_long=1; st_short=0.
  - hw_light=001 (green); farm_light=100 (red); car_pend=0; synchroniser flops=0.
- st_long is 1 during reset so the first clk edge after release clears the timer, whose done output has no reset.
- States and encodings (state_o):
  - HG=0: hw green, farm red
  - HY=1: hw yellow, farm red
  - AR1=2: both red
  - FG=3: hw red, farm green
  - FY=4: hw red, farm yellow
  - AR2=5: both red
- Transitions, evaluated each rising edge:
  - HG->HY when long_done qualified AND car_pend=1; pulse st_short.
  - HY->AR1 on short_done qualified; pulse st_short.
  - AR1->FG on short_done qualified; pulse st_long.
  - FG->FY on long_done qualified; pulse st_short.
  - FY->AR2 on short_done qualified; pulse st_short.
  - AR2->HG on short_done qualified; pulse st_long.
  - Otherwise hold state; st_* = 0.
- Qualification:
  - long_done is ignored in any cycle where st_long=1.
  - short_done is ignored in any cycle where st_short=1.
  - This masks stale done in the cycle before the timer samples its restart.
- st_long and st_short are asserted for exactly one cycle, the first cycle of the new state. They are never both high.
- Lamp outputs are registered and change on the same edge as state.
- Car request path:
  - car_sensor passes through SYNC_STAGES flops.
  - car_pend sets on the edge after the synchronised sensor is 1.
  - car_pend clears on the edge that enters FG.
  - If set and clear coincide, clear wins; a still-present car re-latches on the following edge.
- HG with long_done already high and car_pend rising: leave HG on the edge after car_pend=1 (minimum highway green is enforced only by the timer).
- Unencoded states 6 and 7 recover to HG with st_long=1 and HG lamps on the next edge.
- Reset mid-phase: immediate return to reset values regardless of state; car_pend is lost.
- Timer model for bench (team counter semantics):
  - done drops on the edge sampling st=1.
  - done rises 8 edges later.
  - Each phase therefore lasts 10 cycles from state entry when expired done is acted on immediately.

Test Plan:
- Reset release, car_sensor=0 for 200 cycles -> state_o stays 0, hw_light=001, farm_light=100, st_long high only in the first cycle after release.
- car_sensor=1 from cycle 20, held -> car_pend rises cycle 23 (SYNC_STAGES=2). Then the full cycle runs: HG->HY->AR1->FG->FY->AR2->HG, 10 cycles per timed phase. One st pulse is issued per transition, of the type listed.
- Stale-done check: drive long_done=1 continuously during the st_long cycle on FG entry -> FSM remains in FG and does not jump to FY in that cycle.
- car_sensor pulse of 1 cycle during FG -> car_pend latches. After returning to HG and long_done, the FSM re-enters HY; lamps are never simultaneously non-red on both roads.
- Assert rst for 3 cycles in state FY -> outputs take reset values asynchronously within the same cycle; after release, st_long=1 for one cycle, then the sequence resumes normally.
- Force state register to 6 via bench -> next edge state_o=0, hw_light=001, farm_light=100, st_long=1.
